ring_client_port: RTL

//  Client-side endpoint of the ring node's client interface: drives the node's fromclient/mosivalid
//  and consumes its toclient/misovalid using two-phase toggle handshakes. Queues local send requests,

---
 rtl/ring_pkg.sv | 44 ++++
 rtl/ring_client_fifo.sv | 49 ++++
 rtl/ring_client_port.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring client port: packet field positions,
// payload width helper, reference packet layout and the TX FSM state type.
package ring_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ABITS = 3;

    function automatic int pbits(input int width, input int abits);
        return width - 2 - 2 * abits;
    endfunction

    function automatic int full_pos(input int width);
        return width - 1;
    endfunction

    function automatic int ack_pos(input int width);
        return width - 2;
    endfunction

    function automatic int dst_msb(input int width);
        return width - 3;
    endfunction

    function automatic int src_msb(input int width, input int abits);
        return width - 3 - abits;
    endfunction

    localparam int DEF_PBITS = pbits(DEF_WIDTH, DEF_ABITS);

    typedef struct packed {
        logic                 full;
        logic                 ack;
        logic [DEF_ABITS-1:0] dst;
        logic [DEF_ABITS-1:0] src;
        logic [DEF_PBITS-1:0] payload;
    } ring_pkt_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WAIT  = 2'd1,
        TX_GUARD = 2'd2
    } tx_state_t;

endpackage

// File: rtl/ring_client_fifo.sv
// Small synchronous FIFO with full/empty flags. Push and pop may occur in the
// same cycle, including when full, as long as the caller pops in that cycle.
module ring_client_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

endmodule

// File: rtl/ring_client_port.sv
// Client endpoint of a ring node: launches queued packets to the node and
// unpacks received packets, using two-phase toggle handshakes across clocks.
module ring_client_port
    import ring_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int ABITS   = 3,
    parameter  int TXDEPTH = 2,
    parameter  int RXDEPTH = 2,
    localparam int PBITS   = pbits(WIDTH, ABITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [ABITS-1:0] tx_dst,
    input  logic [PBITS-1:0] tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [ABITS-1:0] rx_src,
    output logic [PBITS-1:0] rx_data,
    output logic [WIDTH-1:0] mosi_data,
    output logic             mosivalid,
    input  logic             mosiack,
    input  logic             txready,
    input  logic [WIDTH-1:0] miso_data,
    input  logic             misovalid,
    output logic             misoack
);
    localparam int QW = ABITS + PBITS;

    logic          ack_s1_q, ack_s_q, txr_s1_q, txr_s_q, val_s1_q, val_s_q;
    logic [QW-1:0] miso_s1_q, miso_s_q;
    logic          rst_done_q;
    tx_state_t     state_q, state_d;
    logic          guard_q, guard_d;
    logic          mosivalid_q, mosivalid_d;
    logic [WIDTH-1:0] mosi_data_q, mosi_data_d;
    logic          misoack_q, misoack_d;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [QW-1:0] tx_head;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [QW-1:0] rx_head;
    logic          unused_hdr_s;

    // The node has already filtered on DST, so the header bits are not needed here.
    assign unused_hdr_s = ^miso_data[WIDTH-1 -: (2 + ABITS)];

    // Two-flop synchronisers for everything driven from the node clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_s1_q  <= 1'b0;
            ack_s_q   <= 1'b0;
            txr_s1_q  <= 1'b0;
            txr_s_q   <= 1'b0;
            val_s1_q  <= 1'b0;
            val_s_q   <= 1'b0;
            miso_s1_q <= '0;
            miso_s_q  <= '0;
        end else begin
            ack_s1_q  <= mosiack;
            ack_s_q   <= ack_s1_q;
            txr_s1_q  <= txready;
            txr_s_q   <= txr_s1_q;
            val_s1_q  <= misovalid;
            val_s_q   <= val_s1_q;
            miso_s1_q <= miso_data[src_msb(WIDTH, ABITS) -: QW];
            miso_s_q  <= miso_s1_q;
        end
    end

    assign tx_ready = rst_done_q && !tx_full;
    assign tx_push  = tx_valid && tx_ready;

    ring_client_fifo #(.DEPTH(TXDEPTH), .DW(QW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .wdata ({tx_dst, tx_data}),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // TX launch FSM: one outstanding toggle at a time, then a guard so the
    // synchronised txready has caught up with the node before the next launch.
    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        mosivalid_d = mosivalid_q;
        mosi_data_d = mosi_data_q;
        tx_pop      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty && (ack_s_q == mosivalid_q) && txr_s_q) begin
                    mosi_data_d = {1'b1, 1'b0, tx_head[QW-1 -: ABITS], {ABITS{1'b0}}, tx_head[PBITS-1:0]};
                    tx_pop      = 1'b1;
                    mosivalid_d = ~mosivalid_q;
                    state_d     = TX_WAIT;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_WAIT: begin
                if (ack_s_q == mosivalid_q) begin
                    guard_d = 1'b0;
                    state_d = TX_GUARD;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            TX_GUARD: begin
                guard_d = ~guard_q;
                if (guard_q) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_GUARD;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    assign rx_pop    = !rx_empty && rx_ready;
    assign rx_push   = (val_s_q != misoack_q) && (!rx_full || rx_pop);
    assign misoack_d = misoack_q ^ rx_push;

    ring_client_fifo #(.DEPTH(RXDEPTH), .DW(QW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (miso_s_q),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Control and handshake output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            guard_q     <= 1'b0;
            mosivalid_q <= 1'b0;
            mosi_data_q <= '0;
            misoack_q   <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            mosivalid_q <= mosivalid_d;
            mosi_data_q <= mosi_data_d;
            misoack_q   <= misoack_d;
            rst_done_q  <= 1'b1;
        end
    end

    assign mosi_data = mosi_data_q;
    assign mosivalid = mosivalid_q;
    assign misoack   = misoack_q;
    assign rx_valid  = !rx_empty;
    assign rx_src    = rx_head[QW-1 -: ABITS];
    assign rx_data   = rx_head[PBITS-1:0];

endmodule
